// File: rtl/data_memory_pkg.sv
`default_nettype none
// ============================================================================
// Package     : data_memory_pkg
// Description : Shared types and default sizes for the data memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package data_memory_pkg;

  localparam int DEFAULT_DEPTH  = 64;
  localparam int DEFAULT_DATA_W = 64;
  localparam int DEFAULT_ADDR_W = 64;

  // Controller sequencing states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_DATA  = 3'd3,
    ST_ERR      = 3'd4
  } state_t;

  // Identifies which of the two requesters owns the current access
  typedef logic requester_id_t;

endpackage : data_memory_pkg
`default_nettype wire

// File: rtl/data_memory_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_2
// Description : Two-way round-robin arbiter. On a tie the requester that was
//               not granted last wins; a lone request always wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_2
  import data_memory_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [1:0]    req,
  output logic          grant_valid,
  output requester_id_t grant
);

  // Starts at 1 so requester 0 wins the first tie after reset
  requester_id_t last_gnt;

  // Pick the winner from the current requests and grant history
  always_comb begin
    grant = 1'b0;
    if (req == 2'b11) begin
      grant = ~last_gnt;
    end else if (req[1]) begin
      grant = 1'b1;
    end
    grant_valid = enable & (|req);
  end

  // Remember every grant, including ones that later end in an error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (grant_valid) begin
      last_gnt <= grant;
    end
  end

endmodule : rr_arbiter_2
`default_nettype wire

// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_arbiter
// Description : Shares one single-port data memory between a CPU port (0) and
//               a DMA/debug port (1). Sequences the memory's falling-edge
//               write / rising-edge registered read and blocks out-of-range
//               addresses from ever reaching the array.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_arbiter
  import data_memory_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              Req0,
  input  logic              Write0,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [DATA_W-1:0] WData0,
  output logic              Ack0,
  output logic              Err0,
  output logic [DATA_W-1:0] RData0,
  input  logic              Req1,
  input  logic              Write1,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData1,
  output logic              Ack1,
  output logic              Err1,
  output logic [DATA_W-1:0] RData1,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] MemReadData
);

  state_t        state;
  state_t        state_nxt;
  requester_id_t owner;
  logic          write_flag;

  logic          grant_valid;
  requester_id_t grant;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              addr_bad;

  // The arbiter only looks at requests while the memory is free
  rr_arbiter_2 u_arb (
    .clk         (Clock),
    .rst_n       (ResetN),
    .enable      (state == ST_IDLE),
    .req         ({Req1, Req0}),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // Steer the winning requester's fields toward the latch registers
  always_comb begin
    sel_write = Write0;
    sel_addr  = Addr0;
    sel_wdata = WData0;
    if (grant) begin
      sel_write = Write1;
      sel_addr  = Addr1;
      sel_wdata = WData1;
    end
  end

  // Full-width unsigned compare: all-ones must be rejected too
  assign addr_bad = (sel_addr >= ADDR_W'(DEPTH));

  // Next-state decode for the access sequencer
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          if (addr_bad) begin
            state_nxt = ST_ERR;
          end else if (sel_write) begin
            state_nxt = ST_WR;
          end else begin
            state_nxt = ST_RD_ISSUE;
          end
        end
      end
      ST_RD_ISSUE: state_nxt = ST_RD_DATA;
      ST_WR,
      ST_RD_DATA,
      ST_ERR:      state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset aborts any access in flight immediately
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture owner and request fields at grant so later changes are ignored
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      owner        <= 1'b0;
      write_flag   <= 1'b0;
      MemAddress   <= '0;
      MemWriteData <= '0;
    end else if (grant_valid) begin
      owner        <= grant;
      write_flag   <= sel_write;
      MemAddress   <= sel_addr;
      MemWriteData <= sel_wdata;
    end
  end

  // Memory strobes come straight from the state register so they can never
  // overlap and fall as soon as reset asserts
  assign MemRead  = (state == ST_RD_ISSUE);
  assign MemWrite = (state == ST_WR);

  // Route completion, error and read data to the owning requester only
  always_comb begin
    logic ack_any;
    logic rd_done;
    ack_any = (state == ST_WR) || (state == ST_RD_DATA) || (state == ST_ERR);
    rd_done = (state == ST_RD_DATA) && !write_flag;
    Ack0    = ack_any && (owner == 1'b0);
    Ack1    = ack_any && (owner == 1'b1);
    Err0    = (state == ST_ERR) && (owner == 1'b0);
    Err1    = (state == ST_ERR) && (owner == 1'b1);
    RData0  = (rd_done && (owner == 1'b0)) ? MemReadData : '0;
    RData1  = (rd_done && (owner == 1'b1)) ? MemReadData : '0;
  end

endmodule : data_memory_arbiter
`default_nettype wire

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-requester controller that shares the single-port 64-entry data memory between a CPU load/store port (requester 0) and a DMA/debug port (requester 1). It arbitrates round-robin and sequences the memory's split-edge protocol: write on the falling edge, registered read on the rising edge. It also range-checks addresses, so out-of-range accesses never reach the array. It sits directly in front of the data memory, and its memory-side ports connect one-to-one to that memory's read/write/address/data pins.

## Interface
- DEPTH, 64, number of memory words; a legal address is < DEPTH
- DATA_W, 64, data width
- ADDR_W, 64, address width
- Clock  input  1  single clock for all logic
- ResetN  input  1  asynchronous, active-low reset
- ReqN (N=0,1)  input  1  request; held until AckN
- WriteN  input  1  1 = write, 0 = read; stable while ReqN
- AddrN  input  ADDR_W  word address; stable while ReqN
- WDataN  input  DATA_W  write data; stable while ReqN
- AckN  output  1  one-cycle completion pulse
- ErrN  output  1  high with AckN when the address was out of range
- RDataN  output  DATA_W  read data; valid only while AckN is high for a read, 0 otherwise
- MemAddress  output  ADDR_W  to memory Address
- MemWriteData  output  DATA_W  to memory WriteData
- MemRead  output  1  to memory MemoryRead
- MemWrite  output  1  to memory MemoryWrite
- MemReadData  input  DATA_W  from memory ReadData

## Operation
- FSM states: IDLE, WR, RD_ISSUE, RD_DATA, ERR.
- IDLE: if any ReqN is high, grant one requester.
  - On grant, latch Owner, AddrN into MemAddress, WDataN into MemWriteData, and the write flag.
  - Next state is ERR if AddrN >= DEPTH, else WR if WriteN, else RD_ISSUE.
- Arbitration: a single request is always granted. Simultaneous requests go to the requester not granted last. LastGnt updates on every grant, including grants that end in ERR.
- WR: MemWrite=1 and MemRead=0; the memory writes on the falling edge inside this cycle. AckOwner=1. Next state is IDLE.
- RD_ISSUE: MemRead=1; the memory captures at the rising edge ending this cycle. No Ack. Next state is RD_DATA.
- RD_DATA: MemRead=0. RDataOwner=MemReadData and AckOwner=1. Next state is IDLE.
- ERR: AckOwner=1 and ErrOwner=1. MemRead and MemWrite stay 0. Next state is IDLE.
- MemRead and MemWrite are decoded from the state register only and are never high together.
- Protocol violation: ReqN dropped or its fields changed after grant. The access completes using the latched values and Ack still pulses.
- A requester that holds ReqN high after AckN is treated as a new request. It is arbitrated in the next IDLE cycle.

## Timing
- Reset values: state IDLE, LastGnt=1 (so requester 0 wins the first tie), Owner=0, MemAddress=0, MemWriteData=0, MemRead=0, MemWrite=0, AckN=0, ErrN=0, RDataN=0.
- Latency from IDLE cycle T, with ReqN sampled high:
  - write: AckN in T+1
  - read: AckN and data in T+2
  - error: AckN and ErrN in T+1
- Throughput per requester with no contention: one write per 2 cycles, one read per 3 cycles.
- Reset asserted mid-operation: the FSM goes to IDLE at once and MemRead/MemWrite drop asynchronously. A write whose falling edge has not yet occurred is aborted. No Ack is issued for the aborted access.
- Reset release: the first grant can occur in the first clock cycle after deassertion.
- Address compare is full ADDR_W width and unsigned. DEPTH-1 is legal; DEPTH and above (including all-ones) give an error.

## Structure
- Package data_memory_pkg holds:
  - the state enum typedef (IDLE, WR, RD_ISSUE, RD_DATA, ERR)
  - default DEPTH and DATA_W constants
  - a RequesterId typedef (1 bit)
- One sub-module, rr_arbiter_2: two requests, the LastGnt flop and the grant output. The FSM enables it only in IDLE.
- The top level holds the FSM, the latch registers, the range check and the Ack/RData steering.

## Test plan
- Write then read, requester 0: write addr 5 with 0xDEADBEEF → Ack0 at T+1. Read addr 5 → Ack0 at T+2 with RData0=0xDEADBEEF, Err0=0.
- Tie, both reading from reset: Req0 and Req1 high together → requester 0 served first, then requester 1. Repeat the tie → requester 0 again, since LastGnt=1 after serving requester 1.
- Range boundary:
  - read addr 63 → normal read
  - write addr 64 → Ack with Err at T+1, MemWrite never high, memory contents unchanged
  - addr 0xFFFF_FFFF_FFFF_FFFF → Err
- Back-to-back: Req1 held high for three writes to addrs 0,1,2 → Ack1 every 2 cycles, all three words read back correctly.
- Reset mid-write: assert ResetN low during WR before the falling edge → MemWrite drops immediately, no Ack, the old word remains, state is IDLE after release.
- Fields changed after grant: change Addr0 during RD_ISSUE → the read returns data for the latched address.
